ball_sched: RTL and testbench
=============================

BALL_SCHED -- requirements
Module: ball_sched

Interface
REQ-001 SHALL have parameter N_OBJ, default 4, number of ball objects (fixed at 4 for this revision).
REQ-002 SHALL have parameter BALL_SIZE, default 4, ball size in pixels and boundary margin.
REQ-003 SHALL have parameter H_MAX, default 640, visible width.
REQ-004 SHALL have parameter V_MAX, default 480, visible height.
REQ-005 SHALL have port clk  input  1  single clock for all logic (25 MHz pixel clock).
REQ-006 SHALL have port res  input  1  reset: asynchronous, active-low.
REQ-007 SHALL have port vsync  input  1  frame sync, synchronous to clk.
REQ-008 SHALL have port stop  input  1  level; 1 freezes motion.
REQ-009 SHALL have port step  input  1  one-cycle pulse; requests a single frame advance while stopped.
REQ-010 SHALL have port cfg_valid  input  1  velocity write request.
REQ-011 SHALL have port cfg_ready  output  1  velocity write can be accepted this cycle.
REQ-012 SHALL have port cfg_idx  input  2  target object.
REQ-013 SHALL have port cfg_hvel  input  10  new H velocity, two's complement.
REQ-014 SHALL have port cfg_vvel  input  10  new V velocity, two's complement.
REQ-015 SHALL have port pos_h  output  10*N_OBJ  H positions; object i at bits [10i+9:10i].
REQ-016 SHALL have port pos_v  output  10*N_OBJ  V positions, same packing.
REQ-017 SHALL have port busy  output  1  update sequence in progress.
REQ-018 SHALL have port frame_done  output  1  one-cycle pulse at end of each update sequence.

Function
REQ-019 SHALL detect vs_rise = vsync & ~vsync_q, where vsync_q is vsync registered one cycle.
REQ-020 SHALL implement states IDLE, ADD, CHECK, DONE, with object index idx (2 bits).
REQ-021 SHALL leave IDLE for ADD with idx=0 on vs_rise when stop=0, or when stop=1 and step_pend=1.
REQ-022 SHALL ignore vs_rise when stop=1 and step_pend=0.
REQ-023 SHALL set step_pend on a step pulse and clear it when the FSM leaves IDLE; a step arriving while busy SHALL stay pending; a step with stop=0 SHALL also be consumed at the next vs_rise.
REQ-024 SHALL, in ADD, write pos_h[idx] += hvel[idx] and pos_v[idx] += vvel[idx] through one shared pair of 10-bit adders, mod 1024.
REQ-025 SHALL, in CHECK, negate hvel[idx] (two's complement) if pos_h[idx] <= BALL_SIZE or >= H_MAX-BALL_SIZE, and independently negate vvel[idx] under the same rule with V_MAX; comparisons are unsigned on the updated position.
REQ-026 SHALL go CHECK->ADD with idx+1 when idx<N_OBJ-1, otherwise CHECK->DONE.
REQ-027 SHALL go DONE->IDLE unconditionally, with frame_done=1 only in DONE.
REQ-028 SHALL drive busy=1 in every state except IDLE, giving 2*N_OBJ+1 = 9 busy cycles per frame.
REQ-029 SHALL drive cfg_ready = (state==IDLE) & ~vs_rise; on vs_rise the frame update wins and the write waits.
REQ-030 SHALL, on cfg_valid & cfg_ready, load hvel/vvel[cfg_idx] at that clock edge without changing position.
REQ-031 SHALL ignore stop changes while busy, so a started sequence always completes.
REQ-032 SHALL register all outputs except cfg_ready and busy, which decode state combinationally.

Reset
REQ-033 SHALL, on res=0 at any time including mid-sequence, asynchronously set state=IDLE, idx=0, step_pend=0, vsync_q=0, every pos_h=316, every pos_v=236, every hvel=2 and every vvel=2; frame_done SHALL be 0 while reset is held.

Verification
REQ-034 SHALL cover this case: reset, stop=0, one vsync rise -> busy high for 9 cycles, frame_done pulses once, all objects at (318,238).
REQ-035 SHALL cover this case: cfg object 1 to hvel=0x3FE (-2) at pos_h=6, then one frame -> pos_h[1]=4, hvel[1]=2 after CHECK.
REQ-036 SHALL cover this case: cfg object 2 to vvel=4 with pos_v=472, one frame -> pos_v[2]=476, vvel[2]=0x3FC.
REQ-037 SHALL cover this case: stop=1 for 3 vsync rises -> no busy and positions unchanged; then a step pulse -> exactly one update on the next vs_rise.
REQ-038 SHALL cover this case: cfg_valid asserted in the vs_rise cycle -> cfg_ready=0 and the write accepted on the first IDLE cycle after DONE.
REQ-039 SHALL cover this case: res pulled low during CHECK of idx=2 -> immediate IDLE, all reset values, no frame_done.

Source files
------------

// File: rtl/ball_sched.sv
// Sequences a 4-object ball motion update on each vsync rise: one ADD and one CHECK cycle per object, then DONE.
// Nine busy cycles per frame. Velocity writes stall (cfg_ready low) until the FSM is idle and no frame is starting.
module ball_sched #(
  parameter int N_OBJ     = 4,
  parameter int BALL_SIZE = 4,
  parameter int H_MAX     = 640,
  parameter int V_MAX     = 480
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 vsync,
  input  logic                 stop,
  input  logic                 step,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_idx,
  input  logic [9:0]           cfg_hvel,
  input  logic [9:0]           cfg_vvel,
  output logic [10*N_OBJ-1:0]  pos_h,
  output logic [10*N_OBJ-1:0]  pos_v,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {IDLE, ADD, CHECK, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic       vsync_q, step_pend, vs_rise, start;
  logic [9:0] ph [N_OBJ];
  logic [9:0] pv [N_OBJ];
  logic [9:0] hv [N_OBJ];
  logic [9:0] vv [N_OBJ];
  logic [9:0] sum_h, sum_v;
  logic       h_edge, v_edge;

  assign vs_rise   = vsync & ~vsync_q;
  assign busy      = (state != IDLE);
  assign cfg_ready = (state == IDLE) & ~vs_rise;

  // One shared adder pair and comparator pair, steered by idx.
  assign sum_h  = ph[idx] + hv[idx];
  assign sum_v  = pv[idx] + vv[idx];
  assign h_edge = (ph[idx] <= 10'(BALL_SIZE)) | (ph[idx] >= 10'(H_MAX - BALL_SIZE));
  assign v_edge = (pv[idx] <= 10'(BALL_SIZE)) | (pv[idx] >= 10'(V_MAX - BALL_SIZE));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise && (!stop || step_pend)) begin
          state_nxt = ADD;
          idx_nxt   = 2'd0;
          start     = 1'b1;
        end
      end
      ADD:   state_nxt = CHECK;
      CHECK: begin
        if (idx != 2'(N_OBJ - 1)) begin
          idx_nxt   = idx + 2'd1;
          state_nxt = ADD;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= IDLE;
      idx        <= 2'd0;
      vsync_q    <= 1'b0;
      step_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      vsync_q    <= vsync;
      frame_done <= (state_nxt == DONE);
      // A step coinciding with the frame start is kept for the following frame.
      if (start)
        step_pend <= step;
      else if (step)
        step_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < N_OBJ; i++) begin
        ph[i] <= 10'(H_MAX / 2 - BALL_SIZE);
        pv[i] <= 10'(V_MAX / 2 - BALL_SIZE);
        hv[i] <= 10'd2;
        vv[i] <= 10'd2;
      end
    end else begin
      if (state == ADD) begin
        ph[idx] <= sum_h;
        pv[idx] <= sum_v;
      end
      if (state == CHECK) begin
        if (h_edge) hv[idx] <= -hv[idx];
        if (v_edge) vv[idx] <= -vv[idx];
      end
      if (cfg_valid && cfg_ready) begin
        hv[cfg_idx] <= cfg_hvel;
        vv[cfg_idx] <= cfg_vvel;
      end
    end
  end

  always_comb begin
    pos_h = '0;
    pos_v = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      pos_h[10*i +: 10] = ph[i];
      pos_v[10*i +: 10] = pv[i];
    end
  end

endmodule

// File: tb/tb_ball_sched.sv
// Directed and randomized checks of ball_sched against a frame-level behavioural model.
module tb_ball_sched;

  localparam int BS = 4, HM = 640, VM = 480;

  logic        clk, res, vsync, stop, step, cfg_valid, cfg_ready;
  logic [1:0]  cfg_idx;
  logic [9:0]  cfg_hvel, cfg_vvel;
  logic [39:0] pos_h, pos_v;
  logic        busy, frame_done;

  int checks = 0;
  int errors = 0;

  int mh [4], mv [4], mhv [4], mvv [4];
  bit pend;

  ball_sched dut (
    .clk(clk), .res(res), .vsync(vsync), .stop(stop), .step(step),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_hvel(cfg_hvel), .cfg_vvel(cfg_vvel), .pos_h(pos_h), .pos_v(pos_v),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      mh[i] = 316; mv[i] = 236; mhv[i] = 2; mvv[i] = 2;
    end
    pend = 1'b0;
  endfunction

  // Whole-frame effect: every object moves by its velocity, then bounces off the margins.
  function automatic void m_frame();
    for (int i = 0; i < 4; i++) begin
      mh[i] = (mh[i] + mhv[i]) % 1024;
      mv[i] = (mv[i] + mvv[i]) % 1024;
      if (mh[i] <= BS || mh[i] >= HM - BS) mhv[i] = (1024 - mhv[i]) % 1024;
      if (mv[i] <= BS || mv[i] >= VM - BS) mvv[i] = (1024 - mvv[i]) % 1024;
    end
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string tag);
    logic [39:0] eh, ev;
    for (int i = 0; i < 4; i++) begin
      eh[10*i +: 10] = 10'(mh[i]);
      ev[10*i +: 10] = 10'(mv[i]);
    end
    check({tag, "_pos_h"}, pos_h, eh);
    check({tag, "_pos_v"}, pos_v, ev);
  endtask

  task automatic do_frame(input string tag, input bit step_mid);
    bit upd;
    int bc, fc;
    upd = !stop || pend;
    if (upd) pend = 1'b0;
    bc = 0; fc = 0;
    vsync = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      vsync = 1'b0;
      step  = step_mid && (c == 3);
      if (busy) bc++;
      if (frame_done) fc++;
    end
    step = 1'b0;
    if (upd) m_frame();
    if (step_mid) pend = 1'b1;
    check({tag, "_busy_cycles"}, 40'(bc), upd ? 40'd9 : 40'd0);
    check({tag, "_frame_done"}, 40'(fc), upd ? 40'd1 : 40'd0);
    check_pos(tag);
  endtask

  task automatic cfg_write(input logic [1:0] i, input logic [9:0] h, input logic [9:0] v);
    cfg_valid = 1'b1; cfg_idx = i; cfg_hvel = h; cfg_vvel = v;
    #1;
    check("cfg_ready_idle", 40'(cfg_ready), 40'd1);
    tick();
    cfg_valid = 1'b0;
    mhv[i] = int'(h);
    mvv[i] = int'(v);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    pend = 1'b1;
  endtask

  initial begin
    int first;
    res = 1'b0; vsync = 1'b0; stop = 1'b0; step = 1'b0;
    cfg_valid = 1'b0; cfg_idx = 2'd0; cfg_hvel = 10'd0; cfg_vvel = 10'd0;
    m_reset();
    tick(); tick();
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_frame_done", 40'(frame_done), 40'd0);
    check("rst_cfg_ready", 40'(cfg_ready), 40'd1);
    check_pos("rst");
    res = 1'b1;
    tick();

    // First frame after reset: everything moves to (318,238).
    do_frame("first", 1'b0);
    check("first_h0", 40'(pos_h[9:0]), 40'd318);
    check("first_v3", 40'(pos_v[39:30]), 40'd238);

    // Drive object 1 down to pos_h=6, then bounce off the left margin.
    cfg_write(2'd1, 10'h3F8, 10'd2);
    for (int f = 0; f < 39; f++) do_frame("walk_left", 1'b0);
    check("left_at6", 40'(pos_h[19:10]), 40'd6);
    cfg_write(2'd1, 10'h3FE, 10'd2);
    do_frame("left_hit", 1'b0);
    check("left_hit_h1", 40'(pos_h[19:10]), 40'd4);
    do_frame("left_after", 1'b0);
    check("left_after_h1", 40'(pos_h[19:10]), 40'd6);

    // Object 2 to pos_v=472, then vvel=4 lands on the bottom margin.
    cfg_write(2'd2, 10'(mhv[2]), 10'((472 - mv[2] + 1024) % 1024));
    do_frame("walk_down", 1'b0);
    check("down_at472", 40'(pos_v[29:20]), 40'd472);
    cfg_write(2'd2, 10'(mhv[2]), 10'd4);
    do_frame("bottom_hit", 1'b0);
    check("bottom_hit_v2", 40'(pos_v[29:20]), 40'd476);
    do_frame("bottom_after", 1'b0);
    check("bottom_after_v2", 40'(pos_v[29:20]), 40'd472);

    // Stopped: vsync ignored until a step, which buys exactly one frame.
    stop = 1'b1;
    for (int f = 0; f < 3; f++) do_frame("stopped", 1'b0);
    pulse_step();
    do_frame("step_frame", 1'b0);
    do_frame("after_step", 1'b0);
    stop = 1'b0;

    // A write presented with the vsync rise waits until the frame completes.
    cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_hvel = 10'd5; cfg_vvel = 10'd7;
    vsync = 1'b1;
    #1;
    check("cfg_ready_vsrise", 40'(cfg_ready), 40'd0);
    first = -1;
    for (int c = 0; c < 12; c++) begin
      tick();
      vsync = 1'b0;
      if (first >= 0) cfg_valid = 1'b0;
      else if (cfg_ready) first = c;
    end
    cfg_valid = 1'b0;
    check("cfg_wait_cycles", 40'(first), 40'd9);
    m_frame();
    mhv[0] = 5; mvv[0] = 7;
    check_pos("cfg_deferred");
    do_frame("cfg_new_vel", 1'b0);

    // Reset asserted during CHECK of object 2.
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    res = 1'b0;
    #1;
    m_reset();
    check("midrst_busy", 40'(busy), 40'd0);
    check("midrst_frame_done", 40'(frame_done), 40'd0);
    check_pos("midrst");
    tick(); tick();
    check("midrst_hold_fd", 40'(frame_done), 40'd0);
    res = 1'b1;
    tick();
    do_frame("post_rst", 1'b0);
    check("post_rst_h2", 40'(pos_h[29:20]), 40'd318);

    // Randomized mix of writes, frames, stops and steps.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: cfg_write(2'($urandom_range(0, 3)), 10'($urandom), 10'($urandom));
        1: begin stop = 1'b0; do_frame("rnd_run", 1'($urandom_range(0, 1))); end
        2: begin
          stop = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 1) pulse_step();
          do_frame("rnd_stop", 1'($urandom_range(0, 1)));
        end
        default: begin
          pulse_step();
          stop = 1'($urandom_range(0, 1));
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
